// File: rtl/dot_accum_if.sv
// dot_accum_if: product stream in, packet result out, both valid/ready
interface dot_accum_if #(
    parameter int W     = 32,
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/dot_accum.sv
// dot_accum: sums each packet of unsigned product terms into a wide result
module dot_accum #(
    parameter int W     = 32,
    parameter int ACC_W = 40,
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    dot_accum_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;
    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [ACC_W:0]   sum;
    logic             ovf;
    logic             ovf_next;
    logic             first;
    logic             beat;
    assign bus.in_ready  = (state == HOLD) ? bus.out_ready : 1'b1;
    assign bus.out_valid = state == HOLD;
    assign beat          = bus.in_valid && bus.in_ready;
    // any beat taken outside ACC opens a new packet, including the no-bubble HOLD case
    assign first    = state != ACC;
    assign sum      = (first ? '0 : {1'b0, acc}) + (ACC_W+1)'(bus.in_data);
    assign cnt_next = first ? CNT_W'(1) : (&cnt ? cnt : cnt + CNT_W'(1));
    assign ovf_next = !first && (ovf || sum[ACC_W]);
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            ovf           <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_count <= '0;
            bus.out_ovf   <= 1'b0;
        end else if (beat) begin
            acc   <= sum[ACC_W-1:0];
            cnt   <= cnt_next;
            ovf   <= ovf_next;
            state <= bus.in_last ? HOLD : ACC;
            if (bus.in_last) begin
                bus.out_sum   <= sum[ACC_W-1:0];
                bus.out_count <= cnt_next;
                bus.out_ovf   <= ovf_next;
            end
        end else if (state == HOLD && bus.out_ready) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_dot_accum.sv
// tb_dot_accum: two widths (40/8 and 32/4) driven in lockstep, results scoreboarded
module tb_dot_accum;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [39:0] sa;
        logic [7:0]  ca;
        logic        oa;
        logic [31:0] sb;
        logic [3:0]  cb;
        logic        ob;
    } exp_t;
    typedef struct {
        int          n;
        logic [31:0] t0, t1, t2, t3;
        exp_t        e;
    } vec_t;

    exp_t q[$];
    vec_t vecs[8];

    dot_accum_if ia ();
    dot_accum_if #(.W(32), .ACC_W(32), .CNT_W(4)) ib ();

    assign ia.in_valid  = in_valid;
    assign ia.in_data   = in_data;
    assign ia.in_last   = in_last;
    assign ia.out_ready = out_ready;
    assign ib.in_valid  = in_valid;
    assign ib.in_data   = in_data;
    assign ib.in_last   = in_last;
    assign ib.out_ready = out_ready;

    dot_accum u_a (.clk(clk), .reset(reset), .bus(ia.slave));
    dot_accum #(.W(32), .ACC_W(32), .CNT_W(4)) u_b (.clk(clk), .reset(reset), .bus(ib.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mke(input logic [39:0] sa, input logic [7:0] ca, input logic oa,
                                 input logic [31:0] sb, input logic [3:0] cb, input logic ob);
        exp_t e;
        e.sa = sa; e.ca = ca; e.oa = oa; e.sb = sb; e.cb = cb; e.ob = ob;
        return e;
    endfunction

    function automatic vec_t mkv(input int n, input logic [31:0] t0, input logic [31:0] t1,
                                 input logic [31:0] t2, input logic [31:0] t3, input exp_t e);
        vec_t v;
        v.n = n; v.t0 = t0; v.t1 = t1; v.t2 = t2; v.t3 = t3; v.e = e;
        return v;
    endfunction

    function automatic logic [31:0] term(input vec_t v, input int i);
        return i == 0 ? v.t0 : i == 1 ? v.t1 : i == 2 ? v.t2 : v.t3;
    endfunction

    // called at a falling edge; returns at the falling edge after the beat was taken
    task automatic send_beat(input logic [31:0] d, input logic l);
        int k = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        while (!ia.in_ready && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (k == 50) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: in_ready stayed 0 for %0d cycles, required 1", k);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
    endtask

    // result monitor: compares whenever a result is presented, pops on handshake
    always @(negedge clk) begin
        #2;
        if (!reset && ia.out_valid) begin
            if (q.size() == 0) begin
                if (out_ready) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: sum %0h with no result expected", ia.out_sum);
                end
            end else begin
                chk("sum_a",   ia.out_sum,   q[0].sa);
                chk("count_a", ia.out_count, q[0].ca);
                chk("ovf_a",   ia.out_ovf,   q[0].oa);
                chk("valid_b", ib.out_valid, 1);
                chk("sum_b",   ib.out_sum,   q[0].sb);
                chk("count_b", ib.out_count, q[0].cb);
                chk("ovf_b",   ib.out_ovf,   q[0].ob);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mkv(1,   32'd5, 0, 0, 0,          mke(40'd5, 8'd1, 0, 32'd5, 4'd1, 0));
        vecs[1] = mkv(4,   32'd1, 32'd2, 32'd3, 32'd4, mke(40'd10, 8'd4, 0, 32'd10, 4'd4, 0));
        vecs[2] = mkv(2,   32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                      mke(40'h01_0000_0001, 8'd2, 0, 32'd1, 4'd2, 1));
        vecs[3] = mkv(1,   32'd7, 0, 0, 0,          mke(40'd7, 8'd1, 0, 32'd7, 4'd1, 0));
        vecs[4] = mkv(20,  32'd1, 32'd1, 32'd1, 32'd1, mke(40'd20, 8'd20, 0, 32'd20, 4'd15, 0));
        vecs[5] = mkv(3,   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                      mke(40'h01_8000_0000, 8'd3, 0, 32'h8000_0000, 4'd3, 1));
        vecs[6] = mkv(1,   32'hFFFF_FFFF, 0, 0, 0,
                      mke(40'h00_FFFF_FFFF, 8'd1, 0, 32'hFFFF_FFFF, 4'd1, 0));
        vecs[7] = mkv(300, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                      mke(40'd188978560724, 8'd255, 1, 32'hFFFF_FED4, 4'd15, 1));

        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid_a", ia.out_valid, 0);
        chk("rst_ready_a", ia.in_ready,  1);
        chk("rst_sum_a",   ia.out_sum,   0);
        chk("rst_count_a", ia.out_count, 0);
        chk("rst_ovf_a",   ia.out_ovf,   0);
        chk("rst_valid_b", ib.out_valid, 0);

        // single-term latency and release
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'd5; in_last = 1'b1;
        q.push_back(mke(40'd5, 8'd1, 0, 32'd5, 4'd1, 0));
        #1;
        chk("lat_pre_valid", ia.out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("lat_valid", ia.out_valid, 1);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("lat_hold_valid", ia.out_valid, 1);
        @(negedge clk);
        #1;
        chk("lat_release_valid", ia.out_valid, 0);
        @(negedge clk);

        foreach (vecs[v]) begin
            q.push_back(vecs[v].e);
            for (int i = 0; i < vecs[v].n; i++) send_beat(term(vecs[v], i), i == vecs[v].n - 1);
        end
        drain();

        // backpressure, then no-bubble acceptance on release
        out_ready = 1'b0;
        q.push_back(mke(40'd11, 8'd1, 0, 32'd11, 4'd1, 0));
        send_beat(32'd11, 1'b1);
        in_valid = 1'b1; in_data = 32'd12; in_last = 1'b1;
        q.push_back(mke(40'd12, 8'd1, 0, 32'd12, 4'd1, 0));
        repeat (3) begin
            #1;
            chk("bp_ready_a", ia.in_ready,  0);
            chk("bp_ready_b", ib.in_ready,  0);
            chk("bp_valid_a", ia.out_valid, 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", ia.in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("no_bubble_valid", ia.out_valid, 1);
        @(negedge clk);
        drain();

        // reset mid-packet discards partial sum
        in_valid = 1'b1; in_data = 32'd100; in_last = 1'b0;
        @(negedge clk);
        in_data = 32'd200;
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_valid", ia.out_valid, 0);
        chk("rst_mid_ready", ia.in_ready,  1);
        @(negedge clk);
        q.push_back(mke(40'd9, 8'd1, 0, 32'd9, 4'd1, 0));
        send_beat(32'd9, 1'b1);
        drain();

        // reset while a result is pending
        out_ready = 1'b0;
        send_beat(32'd13, 1'b1);
        #1;
        chk("pend_valid", ia.out_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_hold_valid", ia.out_valid, 0);
        chk("rst_hold_sum",   ia.out_sum,   0);
        chk("rst_hold_valid_b", ib.out_valid, 0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
